// File: rtl/reservation_station_if.sv
// Issue, result-broadcast and dispatch bundle between decoder, CDB sources,
// the reservation station and the ALU.
interface reservation_station_if #(
  parameter int ROB_W = 4,
  parameter int OP_W  = 6
);
  logic             issue_rs_ready;
  logic [ROB_W-1:0] issue_rob_index;
  logic [OP_W-1:0]  issue_op;
  logic [31:0]      issue_rs1_val;
  logic [ROB_W-1:0] issue_rs1_depend;
  logic [31:0]      issue_rs2_val;
  logic [ROB_W-1:0] issue_rs2_depend;
  logic [31:0]      issue_imm;
  logic [31:0]      issue_PC;
  logic             issue_pred_br;

  logic             alu_ready;
  logic [ROB_W-1:0] alu_rob_index;
  logic [31:0]      alu_result;
  logic             lsb_ready;
  logic [ROB_W-1:0] lsb_rob_index;
  logic [31:0]      lsb_result;

  logic             rs_full;
  logic             rs_to_alu_ready;
  logic [OP_W-1:0]  rs_to_alu_op;
  logic [31:0]      rs_to_alu_rs1_val;
  logic [31:0]      rs_to_alu_rs2_val;
  logic [31:0]      rs_to_alu_imm;
  logic [31:0]      rs_to_alu_PC;
  logic [ROB_W-1:0] rs_to_alu_rob_index;
  logic             rs_to_alu_pred_br;

  modport master (
    output issue_rs_ready, issue_rob_index, issue_op, issue_rs1_val,
           issue_rs1_depend, issue_rs2_val, issue_rs2_depend, issue_imm,
           issue_PC, issue_pred_br,
    output alu_ready, alu_rob_index, alu_result,
           lsb_ready, lsb_rob_index, lsb_result,
    input  rs_full, rs_to_alu_ready, rs_to_alu_op, rs_to_alu_rs1_val,
           rs_to_alu_rs2_val, rs_to_alu_imm, rs_to_alu_PC,
           rs_to_alu_rob_index, rs_to_alu_pred_br
  );

  modport slave (
    input  issue_rs_ready, issue_rob_index, issue_op, issue_rs1_val,
           issue_rs1_depend, issue_rs2_val, issue_rs2_depend, issue_imm,
           issue_PC, issue_pred_br,
    input  alu_ready, alu_rob_index, alu_result,
           lsb_ready, lsb_rob_index, lsb_result,
    output rs_full, rs_to_alu_ready, rs_to_alu_op, rs_to_alu_rs1_val,
           rs_to_alu_rs2_val, rs_to_alu_imm, rs_to_alu_PC,
           rs_to_alu_rob_index, rs_to_alu_pred_br
  );
endinterface

// File: rtl/reservation_station.sv
// ALU reservation station: allocates into the lowest free slot, snoops ALU/LSB
// result broadcasts, and dispatches the lowest-index ready entry each cycle.
module reservation_station #(
  parameter int RS_SIZE = 16,
  parameter int ROB_W   = 4,
  parameter int OP_W    = 6
) (
  input logic                  clk_in,
  input logic                  rst_in,
  input logic                  rdy_in,
  input logic                  clr_in,
  reservation_station_if.slave rs_if
);
  localparam int CNT_W = $clog2(RS_SIZE + 1);
  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  logic             busy_q    [RS_SIZE];
  logic             busy_d    [RS_SIZE];
  logic [OP_W-1:0]  op_q      [RS_SIZE];
  logic [OP_W-1:0]  op_d      [RS_SIZE];
  logic [31:0]      rs1_val_q [RS_SIZE];
  logic [31:0]      rs1_val_d [RS_SIZE];
  logic [ROB_W-1:0] rs1_dep_q [RS_SIZE];
  logic [ROB_W-1:0] rs1_dep_d [RS_SIZE];
  logic [31:0]      rs2_val_q [RS_SIZE];
  logic [31:0]      rs2_val_d [RS_SIZE];
  logic [ROB_W-1:0] rs2_dep_q [RS_SIZE];
  logic [ROB_W-1:0] rs2_dep_d [RS_SIZE];
  logic [31:0]      imm_q     [RS_SIZE];
  logic [31:0]      imm_d     [RS_SIZE];
  logic [31:0]      pc_q      [RS_SIZE];
  logic [31:0]      pc_d      [RS_SIZE];
  logic [ROB_W-1:0] rob_q     [RS_SIZE];
  logic [ROB_W-1:0] rob_d     [RS_SIZE];
  logic             pred_q    [RS_SIZE];
  logic             pred_d    [RS_SIZE];

  logic             out_ready_q, out_ready_d;
  logic [OP_W-1:0]  out_op_q, out_op_d;
  logic [31:0]      out_rs1_q, out_rs1_d;
  logic [31:0]      out_rs2_q, out_rs2_d;
  logic [31:0]      out_imm_q, out_imm_d;
  logic [31:0]      out_pc_q, out_pc_d;
  logic [ROB_W-1:0] out_rob_q, out_rob_d;
  logic             out_pred_q, out_pred_d;

  logic [CNT_W-1:0] busy_cnt;
  logic             disp_found, free_found;
  logic [IDX_W-1:0] disp_idx, free_idx;

  // Tag 0 means "no dependency", so it must never match; ALU beats LSB.
  function automatic logic [ROB_W+31:0] wake(
    input logic [ROB_W-1:0] dep,
    input logic [31:0]      val,
    input logic             a_vld,
    input logic [ROB_W-1:0] a_tag,
    input logic [31:0]      a_res,
    input logic             l_vld,
    input logic [ROB_W-1:0] l_tag,
    input logic [31:0]      l_res
  );
    if (dep != '0 && a_vld && a_tag == dep)
      return {{ROB_W{1'b0}}, a_res};
    else if (dep != '0 && l_vld && l_tag == dep)
      return {{ROB_W{1'b0}}, l_res};
    else
      return {dep, val};
  endfunction

  always_comb begin
    busy_cnt   = '0;
    disp_found = 1'b0;
    disp_idx   = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (busy_q[i])
        busy_cnt = busy_cnt + CNT_W'(1);
      if (!disp_found && busy_q[i] && rs1_dep_q[i] == '0 && rs2_dep_q[i] == '0) begin
        disp_found = 1'b1;
        disp_idx   = IDX_W'(i);
      end
      if (!free_found && !busy_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  assign rs_if.rs_full = (busy_cnt >= CNT_W'(RS_SIZE - 1));

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      busy_d[i]    = busy_q[i];
      op_d[i]      = op_q[i];
      rs1_val_d[i] = rs1_val_q[i];
      rs1_dep_d[i] = rs1_dep_q[i];
      rs2_val_d[i] = rs2_val_q[i];
      rs2_dep_d[i] = rs2_dep_q[i];
      imm_d[i]     = imm_q[i];
      pc_d[i]      = pc_q[i];
      rob_d[i]     = rob_q[i];
      pred_d[i]    = pred_q[i];
      if (busy_q[i]) begin
        {rs1_dep_d[i], rs1_val_d[i]} = wake(rs1_dep_q[i], rs1_val_q[i],
          rs_if.alu_ready, rs_if.alu_rob_index, rs_if.alu_result,
          rs_if.lsb_ready, rs_if.lsb_rob_index, rs_if.lsb_result);
        {rs2_dep_d[i], rs2_val_d[i]} = wake(rs2_dep_q[i], rs2_val_q[i],
          rs_if.alu_ready, rs_if.alu_rob_index, rs_if.alu_result,
          rs_if.lsb_ready, rs_if.lsb_rob_index, rs_if.lsb_result);
      end
    end

    out_ready_d = 1'b0;
    out_op_d    = out_op_q;
    out_rs1_d   = out_rs1_q;
    out_rs2_d   = out_rs2_q;
    out_imm_d   = out_imm_q;
    out_pc_d    = out_pc_q;
    out_rob_d   = out_rob_q;
    out_pred_d  = out_pred_q;

    if (disp_found) begin
      out_ready_d      = 1'b1;
      out_op_d         = op_q[disp_idx];
      out_rs1_d        = rs1_val_q[disp_idx];
      out_rs2_d        = rs2_val_q[disp_idx];
      out_imm_d        = imm_q[disp_idx];
      out_pc_d         = pc_q[disp_idx];
      out_rob_d        = rob_q[disp_idx];
      out_pred_d       = pred_q[disp_idx];
      busy_d[disp_idx] = 1'b0;
    end

    // Free slot is chosen from pre-edge busy bits, so a slot freed by this
    // edge's dispatch is never reused until the following edge.
    if (rs_if.issue_rs_ready && free_found) begin
      busy_d[free_idx] = 1'b1;
      op_d[free_idx]   = rs_if.issue_op;
      imm_d[free_idx]  = rs_if.issue_imm;
      pc_d[free_idx]   = rs_if.issue_PC;
      rob_d[free_idx]  = rs_if.issue_rob_index;
      pred_d[free_idx] = rs_if.issue_pred_br;
      {rs1_dep_d[free_idx], rs1_val_d[free_idx]} = wake(rs_if.issue_rs1_depend,
        rs_if.issue_rs1_val,
        rs_if.alu_ready, rs_if.alu_rob_index, rs_if.alu_result,
        rs_if.lsb_ready, rs_if.lsb_rob_index, rs_if.lsb_result);
      {rs2_dep_d[free_idx], rs2_val_d[free_idx]} = wake(rs_if.issue_rs2_depend,
        rs_if.issue_rs2_val,
        rs_if.alu_ready, rs_if.alu_rob_index, rs_if.alu_result,
        rs_if.lsb_ready, rs_if.lsb_rob_index, rs_if.lsb_result);
    end

    if (clr_in) begin
      for (int i = 0; i < RS_SIZE; i++)
        busy_d[i] = 1'b0;
      out_ready_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        busy_q[i]    <= 1'b0;
        op_q[i]      <= '0;
        rs1_val_q[i] <= '0;
        rs1_dep_q[i] <= '0;
        rs2_val_q[i] <= '0;
        rs2_dep_q[i] <= '0;
        imm_q[i]     <= '0;
        pc_q[i]      <= '0;
        rob_q[i]     <= '0;
        pred_q[i]    <= 1'b0;
      end
      out_ready_q <= 1'b0;
      out_op_q    <= '0;
      out_rs1_q   <= '0;
      out_rs2_q   <= '0;
      out_imm_q   <= '0;
      out_pc_q    <= '0;
      out_rob_q   <= '0;
      out_pred_q  <= 1'b0;
    end else if (rdy_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        busy_q[i]    <= busy_d[i];
        op_q[i]      <= op_d[i];
        rs1_val_q[i] <= rs1_val_d[i];
        rs1_dep_q[i] <= rs1_dep_d[i];
        rs2_val_q[i] <= rs2_val_d[i];
        rs2_dep_q[i] <= rs2_dep_d[i];
        imm_q[i]     <= imm_d[i];
        pc_q[i]      <= pc_d[i];
        rob_q[i]     <= rob_d[i];
        pred_q[i]    <= pred_d[i];
      end
      out_ready_q <= out_ready_d;
      out_op_q    <= out_op_d;
      out_rs1_q   <= out_rs1_d;
      out_rs2_q   <= out_rs2_d;
      out_imm_q   <= out_imm_d;
      out_pc_q    <= out_pc_d;
      out_rob_q   <= out_rob_d;
      out_pred_q  <= out_pred_d;
    end
  end

  assign rs_if.rs_to_alu_ready     = out_ready_q;
  assign rs_if.rs_to_alu_op        = out_op_q;
  assign rs_if.rs_to_alu_rs1_val   = out_rs1_q;
  assign rs_if.rs_to_alu_rs2_val   = out_rs2_q;
  assign rs_if.rs_to_alu_imm       = out_imm_q;
  assign rs_if.rs_to_alu_PC        = out_pc_q;
  assign rs_if.rs_to_alu_rob_index = out_rob_q;
  assign rs_if.rs_to_alu_pred_br   = out_pred_q;
endmodule
